dsram_like_slave: RTL and testbench

DSRAM_LIKE_SLAVE -- requirements
Module: dsram_like_slave

---
 rtl/dsram_like_slave.sv | 67 ++++++
 tb/tb_dsram_like_slave.sv | 119 +++++++++++
 2 files changed

// File: rtl/dsram_like_slave.sv
// dsram_like_slave: SRAM-like slave with fixed-latency in-order responses and outstanding-request limit.
// Define DSRAM_STALL_EN to add LFSR-driven pseudo-random addr_ok stalls.
module dsram_like_slave #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  logic [31:0]        mem [2**ADDR_W];
  logic [LATENCY-1:0] vld, rd;
  logic [31:0]        dat [LATENCY];
  logic [2:0]         count;
  logic [3:0]         lanes;
  logic [ADDR_W-1:0]  idx;
  logic               stall_ok, acc;
  logic               unused_addr;
`ifdef DSRAM_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk)
    lfsr <= reset ? 8'hA5 : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign stall_ok = lfsr[1:0] != 2'b00;
`else
  assign stall_ok = 1'b1;
`endif
  assign unused_addr = ^addr[31:ADDR_W+2];
  assign idx     = addr[ADDR_W+1:2];
  assign data_ok = vld[LATENCY-1];
  assign rdata   = data_ok && rd[LATENCY-1] ? dat[LATENCY-1] : '0;
  // A completing response frees a slot in the same cycle it is returned
  assign addr_ok = ~reset && (count < 3'(MAX_OUT) || data_ok) && stall_ok;
  assign acc     = req && addr_ok;
  always_comb
    lanes = size == 2'd0 ? 4'b0001 << addr[1:0] :
            size == 2'd1 ? 4'b0011 << addr[1:0] : 4'b1111 << addr[1:0];
  always_ff @(posedge clk)
    if (acc && wr)
      for (int b = 0; b < 4; b++)
        if (lanes[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  always_ff @(posedge clk) begin
    if (reset) begin
      vld   <= '0;
      count <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) vld[i] <= vld[i-1];
      vld[0] <= acc;
      count  <= acc && !data_ok ? count + 3'd1 : !acc && data_ok ? count - 3'd1 : count;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = LATENCY - 1; i > 0; i--) begin
      rd[i]  <= rd[i-1];
      dat[i] <= dat[i-1];
    end
    rd[0]  <= ~wr;
    dat[0] <= wr ? '0 : mem[idx];
  end
endmodule

// File: tb/tb_dsram_like_slave.sv
// tb_dsram_like_slave: scoreboard bench for dsram_like_slave (default build, no stalls).
module tb_dsram_like_slave;
  localparam int LAT = 2, MAXO = 2;
  logic clk = 0, reset = 1;
  logic req = 0, wr = 0, req4 = 0, wr4 = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic addr_ok, data_ok, addr_ok4, data_ok4;
  logic [31:0] rdata, rdata4;
  int n_chk = 0, n_fail = 0, cnt = 0;
  bit live = 0, done4 = 0;
  bit [LAT-1:0] pipe = '0;
  logic [31:0] q [$];
  logic [31:0] mm [int];

  always #5 clk = ~clk;

  dsram_like_slave u_dut (.clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata));
  dsram_like_slave #(.LATENCY(4), .MAX_OUT(2)) u_dut4 (.clk(clk), .reset(reset), .req(req4), .wr(wr4),
    .size(size), .addr(addr), .wdata(wdata), .addr_ok(addr_ok4), .data_ok(data_ok4), .rdata(rdata4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] e, old;
    bit edok, eaok, acc;
    int wi, st, n;
    req = r; wr = w; size = sz; addr = a; wdata = d;
    @(negedge clk);
    edok = pipe[LAT-1];
    eaok = !reset && (cnt < MAXO || edok);
    chk("addr_ok", addr_ok, eaok);
    if (live) begin
      chk("data_ok", data_ok, edok);
      if (edok && q.size() > 0) begin
        e = q.pop_front();
        chk("rdata", rdata, e);
      end else chk("rdata_idle", rdata, 32'h0);
    end
    acc = r && eaok;
    wi = int'(a[11:2]);
    if (reset) begin
      pipe = '0; cnt = 0; q.delete(); live = 1;
    end else begin
      if (acc) begin
        old = mm.exists(wi) ? mm[wi] : 32'h0;
        if (w) begin
          st = int'(a[1:0]);
          n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
          for (int k = st; k < st + n && k < 4; k++) old[8*k +: 8] = d[8*k +: 8];
          mm[wi] = old;
          q.push_back(32'h0);
        end else q.push_back(old);
      end
      cnt = cnt + int'(acc) - int'(edok);
      pipe = {pipe[LAT-2:0], acc};
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'd0, 32'h0, 32'h0);
  endtask

  // Long-latency instance under continuous requests: two accepts, two stalled cycles, repeat
  initial begin
    @(negedge reset);
    req4 = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("aok4", {31'h0, addr_ok4}, {31'h0, c % 4 < 2});
      chk("dok4", {31'h0, data_ok4}, {31'h0, c >= 4 && c % 4 < 2});
    end
    req4 = 0;
    done4 = 1;
  end

  initial begin
    @(posedge clk); #1;
    idle(2);
    reset = 0;
    step(1, 1, 2'd2, 32'h40, 32'h11223344);
    step(1, 0, 2'd2, 32'h40, 32'h0);
    step(1, 1, 2'd0, 32'h43, 32'hAAAAAAAA);
    step(1, 0, 2'd2, 32'h40, 32'h0);
    step(1, 1, 2'd1, 32'h42, 32'h55665566);
    step(1, 0, 2'd2, 32'h40, 32'h0);
    step(1, 1, 2'd2, 32'h80, 32'h01020304);
    step(1, 1, 2'd3, 32'h81, 32'hDEADBEEF);
    step(1, 0, 2'd2, 32'h80, 32'h0);
    step(1, 1, 2'd1, 32'h83, 32'h77889900);
    step(1, 0, 2'd0, 32'h82, 32'h0);
    step(1, 0, 2'd2, 32'h10000040, 32'h0);
    idle(3);
    for (int i = 0; i < 6; i++) step(1, 0, 2'd2, i % 2 ? 32'h80 : 32'h40, 32'h0);
    idle(3);
    step(1, 1, 2'd2, 32'h44, 32'hCAFEF00D);
    idle(3);
    step(1, 0, 2'd2, 32'h44, 32'h0);
    reset = 1;
    idle(1);
    reset = 0;
    idle(3);
    step(1, 0, 2'd2, 32'h44, 32'h0);
    step(1, 0, 2'd2, 32'h40, 32'h0);
    idle(3);
    for (int i = 0; i < 50 && !done4; i++) @(posedge clk);
    chk("done4", {31'h0, done4}, 32'h1);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
